// File: rtl/mem_lsu.sv
// Memory-stage load/store unit: turns one load/store into a single request/grant/response
// transaction on the data-memory port and returns a lane-aligned, extended load result.
module mem_lsu (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [2:0]  funct3,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic        IM_stall,
  output logic        dm_req,
  output logic        dm_we,
  output logic [31:0] dm_addr,
  output logic [3:0]  dm_wstrb,
  output logic [31:0] dm_wdata,
  input  logic        dm_gnt,
  input  logic        dm_rvalid,
  input  logic [31:0] dm_rdata,
  output logic [31:0] ld_data,
  output logic        DM_stall,
  output logic        misalign
);

  // Handshake: dm_req is a valid that stays high, with every dm_* field frozen, until the
  // cycle dm_gnt is seen high; a read then completes on the first dm_rvalid in WAIT_R only.
  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic        op_valid;
  logic        misaligned_in;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic        load_q;
  logic [2:0]  funct3_q;
  logic [1:0]  lane_q;
  logic [31:0] lane;
  logic [31:0] ld_fmt;

  assign op_valid = mem_read | mem_write;

  always_comb begin
    misaligned_in = 1'b0;
    case (funct3[1:0])
      2'b00:   misaligned_in = 1'b0;
      2'b01:   misaligned_in = addr[0];
      default: misaligned_in = (addr[1:0] != 2'b00);
    endcase
  end

  // Narrow stores are replicated across lanes; the strobes pick the addressed lane.
  always_comb begin
    st_wdata = store_data;
    st_wstrb = 4'b1111;
    case (funct3[1:0])
      2'b00: begin
        st_wdata = {4{store_data[7:0]}};
        st_wstrb = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        st_wdata = {2{store_data[15:0]}};
        st_wstrb = 4'b0011 << addr[1:0];
      end
      default: ;
    endcase
  end

  assign lane = dm_rdata >> {lane_q, 3'b000};

  always_comb begin
    ld_fmt = lane;
    case (funct3_q)
      3'b000:  ld_fmt = {{24{lane[7]}}, lane[7:0]};
      3'b001:  ld_fmt = {{16{lane[15]}}, lane[15:0]};
      3'b100:  ld_fmt = {24'h0, lane[7:0]};
      3'b101:  ld_fmt = {16'h0, lane[15:0]};
      default: ld_fmt = lane;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    DM_stall  = 1'b0;
    case (state)
      IDLE: begin
        DM_stall = op_valid;
        if (op_valid) state_nxt = misaligned_in ? DONE : REQ;
      end
      REQ: begin
        DM_stall = 1'b1;
        if (dm_gnt) state_nxt = load_q ? WAIT_R : DONE;
      end
      WAIT_R: begin
        DM_stall = 1'b1;
        if (dm_rvalid) state_nxt = DONE;
      end
      DONE: begin
        // Leave only when the pipeline advances, so the held EX/MEM op is not re-issued.
        if (!IM_stall) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dm_req   <= 1'b0;
      dm_we    <= 1'b0;
      dm_addr  <= 32'h0;
      dm_wstrb <= 4'h0;
      dm_wdata <= 32'h0;
      ld_data  <= 32'h0;
      misalign <= 1'b0;
      load_q   <= 1'b0;
      funct3_q <= 3'b000;
      lane_q   <= 2'b00;
    end else begin
      case (state)
        IDLE: begin
          if (op_valid) begin
            load_q   <= mem_read;
            funct3_q <= funct3;
            lane_q   <= addr[1:0];
            dm_addr  <= {addr[31:2], 2'b00};
            dm_we    <= ~mem_read;
            dm_wstrb <= mem_read ? 4'h0 : st_wstrb;
            dm_wdata <= st_wdata;
            if (misaligned_in) begin
              misalign <= 1'b1;
              if (mem_read) ld_data <= 32'h0;
            end else begin
              dm_req <= 1'b1;
            end
          end
        end
        REQ: begin
          if (dm_gnt) dm_req <= 1'b0;
        end
        WAIT_R: begin
          if (dm_rvalid) ld_data <= ld_fmt;
        end
        DONE: begin
          if (!IM_stall) misalign <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Directed testbench for mem_lsu: each task drives one scenario and checks against
// hand-computed values.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_read;
  logic        mem_write;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] store_data;
  logic        IM_stall;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [3:0]  dm_wstrb;
  logic [31:0] dm_wdata;
  logic        dm_gnt;
  logic        dm_rvalid;
  logic [31:0] dm_rdata;
  logic [31:0] ld_data;
  logic        DM_stall;
  logic        misalign;

  int checks = 0;
  int failures = 0;

  // Results of the most recent do_access call.
  int          r_stall;
  int          r_req;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_we;
  logic        r_unstable;

  mem_lsu dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write), .funct3(funct3),
    .addr(addr), .store_data(store_data), .IM_stall(IM_stall), .dm_req(dm_req),
    .dm_we(dm_we), .dm_addr(dm_addr), .dm_wstrb(dm_wstrb), .dm_wdata(dm_wdata),
    .dm_gnt(dm_gnt), .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata), .ld_data(ld_data),
    .DM_stall(DM_stall), .misalign(misalign)
  );

  always #5 clk = ~clk;

  // Starts just after a rising edge; returns in the first cycle DM_stall is low.
  task automatic do_access(input logic rd, input logic wr, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] sd,
                           input logic [31:0] rdata, input int gnt_delay, input int rv_delay);
    int rv_cnt;
    mem_read = rd; mem_write = wr; funct3 = f3; addr = a; store_data = sd;
    r_stall = 0; r_req = 0; rv_cnt = 0; r_unstable = 1'b0;
    r_addr = 32'h0; r_wdata = 32'h0; r_wstrb = 4'h0; r_we = 1'b0;
    for (int c = 0; c < 60; c++) begin
      #1;
      if (!DM_stall) break;
      r_stall++;
      dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h0BAD0BAD;
      if (rv_cnt == 1) begin dm_rvalid = 1'b1; dm_rdata = rdata; end
      if (rv_cnt > 0) rv_cnt--;
      if (dm_req) begin
        if (r_req == 0) begin
          r_addr = dm_addr; r_wdata = dm_wdata; r_wstrb = dm_wstrb; r_we = dm_we;
        end else if ({r_addr, r_wdata, r_wstrb, r_we} !== {dm_addr, dm_wdata, dm_wstrb, dm_we}) begin
          r_unstable = 1'b1;
        end
        if (r_req == gnt_delay) begin
          dm_gnt = 1'b1;
          if (rd) rv_cnt = rv_delay + 1;
        end
        r_req++;
      end
      @(posedge clk); #1;
    end
    dm_gnt = 1'b0; dm_rvalid = 1'b0;
  endtask

  task automatic retire();
    @(posedge clk); #1;
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    checks++; if ({dm_req, dm_we, dm_wstrb, misalign} !== 7'h0) begin failures++;
      $display("FAIL reset_ctrl: got req=%b we=%b wstrb=%b mis=%b exp all 0", dm_req, dm_we, dm_wstrb, misalign); end
    checks++; if ({dm_addr, dm_wdata, ld_data} !== 96'h0) begin failures++;
      $display("FAIL reset_data: got addr=%h wdata=%h ld=%h exp 0", dm_addr, dm_wdata, ld_data); end
    checks++; if (DM_stall !== 1'b0) begin failures++;
      $display("FAIL reset_stall: got %b exp 0", DM_stall); end
  endtask

  task automatic test_load_word();
    do_access(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 32'hDEADBEEF, 0, 0);
    checks++; if (r_stall !== 3) begin failures++; $display("FAIL lw_stall: got %0d exp 3", r_stall); end
    checks++; if (ld_data !== 32'hDEADBEEF) begin failures++; $display("FAIL lw_data: got %h exp deadbeef", ld_data); end
    checks++; if (r_addr !== 32'h100 || r_we !== 1'b0 || r_wstrb !== 4'h0) begin failures++;
      $display("FAIL lw_req: got addr=%h we=%b wstrb=%b exp 100/0/0000", r_addr, r_we, r_wstrb); end
    retire();
  endtask

  task automatic test_load_byte_half();
    do_access(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, 32'h80FF1234, 0, 0);
    checks++; if (ld_data !== 32'hFFFFFF80) begin failures++; $display("FAIL lb_data: got %h exp ffffff80", ld_data); end
    checks++; if (r_addr !== 32'h100) begin failures++; $display("FAIL lb_addr: got %h exp 00000100", r_addr); end
    retire();
    do_access(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, 32'h80FF1234, 0, 0);
    checks++; if (ld_data !== 32'h00000080) begin failures++; $display("FAIL lbu_data: got %h exp 00000080", ld_data); end
    retire();
    do_access(1'b1, 1'b0, 3'b101, 32'h102, 32'h0, 32'h80FF1234, 0, 0);
    checks++; if (ld_data !== 32'h000080FF) begin failures++; $display("FAIL lhu_data: got %h exp 000080ff", ld_data); end
    retire();
    do_access(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, 32'h80FF1234, 0, 0);
    checks++; if (ld_data !== 32'hFFFF80FF) begin failures++; $display("FAIL lh_data: got %h exp ffff80ff", ld_data); end
    retire();
  endtask

  task automatic test_store();
    do_access(1'b0, 1'b1, 3'b000, 32'h202, 32'h000000AB, 32'h0, 0, 0);
    checks++; if (r_stall !== 2) begin failures++; $display("FAIL sb_stall: got %0d exp 2", r_stall); end
    checks++; if (r_wdata !== 32'hABABABAB || r_wstrb !== 4'b0100 || r_we !== 1'b1) begin failures++;
      $display("FAIL sb_req: got wdata=%h wstrb=%b we=%b exp abababab/0100/1", r_wdata, r_wstrb, r_we); end
    checks++; if (ld_data !== 32'hFFFF80FF) begin failures++; $display("FAIL sb_ld_hold: got %h exp ffff80ff", ld_data); end
    retire();
    do_access(1'b0, 1'b1, 3'b001, 32'h202, 32'h0000CAFE, 32'h0, 0, 0);
    checks++; if (r_wdata !== 32'hCAFECAFE || r_wstrb !== 4'b1100 || r_addr !== 32'h200) begin failures++;
      $display("FAIL sh_req: got wdata=%h wstrb=%b addr=%h exp cafecafe/1100/200", r_wdata, r_wstrb, r_addr); end
    retire();
    do_access(1'b0, 1'b1, 3'b010, 32'h300, 32'h12345678, 32'h0, 0, 0);
    checks++; if (r_wdata !== 32'h12345678 || r_wstrb !== 4'b1111) begin failures++;
      $display("FAIL sw_req: got wdata=%h wstrb=%b exp 12345678/1111", r_wdata, r_wstrb); end
    retire();
  endtask

  task automatic test_misaligned();
    do_access(1'b1, 1'b0, 3'b010, 32'h101, 32'h0, 32'h0, 0, 0);
    checks++; if (r_stall !== 1 || r_req !== 0) begin failures++;
      $display("FAIL mis_lw_stall: got stall=%0d req=%0d exp 1/0", r_stall, r_req); end
    checks++; if (misalign !== 1'b1 || ld_data !== 32'h0) begin failures++;
      $display("FAIL mis_lw_out: got mis=%b ld=%h exp 1/0", misalign, ld_data); end
    retire();
    #1;
    checks++; if (misalign !== 1'b0) begin failures++; $display("FAIL mis_clear: got %b exp 0", misalign); end
    do_access(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, 32'hCAFEF00D, 0, 0);
    retire();
    do_access(1'b0, 1'b1, 3'b001, 32'h303, 32'h0000BEEF, 32'h0, 0, 0);
    checks++; if (r_stall !== 1 || r_req !== 0 || misalign !== 1'b1) begin failures++;
      $display("FAIL mis_sh: got stall=%0d req=%0d mis=%b exp 1/0/1", r_stall, r_req, misalign); end
    checks++; if (ld_data !== 32'hCAFEF00D) begin failures++; $display("FAIL mis_sh_ld_hold: got %h exp cafef00d", ld_data); end
    retire();
    do_access(1'b1, 1'b0, 3'b000, 32'h105, 32'h0, 32'h00007F00, 0, 0);
    checks++; if (ld_data !== 32'h0000007F || misalign !== 1'b0) begin failures++;
      $display("FAIL lb_odd: got ld=%h mis=%b exp 0000007f/0", ld_data, misalign); end
    retire();
  endtask

  task automatic test_backpressure();
    do_access(1'b0, 1'b1, 3'b010, 32'h400, 32'hA5A55A5A, 32'h0, 3, 0);
    checks++; if (r_stall !== 5 || r_req !== 4) begin failures++;
      $display("FAIL bp_stall: got stall=%0d req=%0d exp 5/4", r_stall, r_req); end
    checks++; if (r_unstable !== 1'b0) begin failures++; $display("FAIL bp_stable: got unstable=%b exp 0", r_unstable); end
    IM_stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++; if (DM_stall !== 1'b0 || dm_req !== 1'b0) begin failures++;
        $display("FAIL bp_done_hold: cycle %0d got stall=%b req=%b exp 0/0", i, DM_stall, dm_req); end
    end
    IM_stall = 1'b0;
    retire();
    #1;
    checks++; if (dm_req !== 1'b0 || DM_stall !== 1'b0) begin failures++;
      $display("FAIL bp_idle: got req=%b stall=%b exp 0/0", dm_req, DM_stall); end
    do_access(1'b1, 1'b0, 3'b010, 32'h404, 32'h0, 32'h31415926, 1, 2);
    checks++; if (r_stall !== 6) begin failures++; $display("FAIL bp_load_stall: got %0d exp 6", r_stall); end
    checks++; if (ld_data !== 32'h31415926) begin failures++; $display("FAIL bp_load_data: got %h exp 31415926", ld_data); end
    retire();
  endtask

  task automatic test_read_wins();
    do_access(1'b1, 1'b1, 3'b010, 32'h600, 32'hFFFFFFFF, 32'h600D600D, 0, 0);
    checks++; if (r_we !== 1'b0 || r_wstrb !== 4'h0 || r_stall !== 3) begin failures++;
      $display("FAIL rw_req: got we=%b wstrb=%b stall=%0d exp 0/0000/3", r_we, r_wstrb, r_stall); end
    checks++; if (ld_data !== 32'h600D600D) begin failures++; $display("FAIL rw_data: got %h exp 600d600d", ld_data); end
    retire();
  endtask

  task automatic test_reset_mid();
    mem_read = 1'b1; funct3 = 3'b010; addr = 32'h500;
    @(posedge clk); #1;
    dm_gnt = 1'b1;
    @(posedge clk); #1;
    dm_gnt = 1'b0;
    checks++; if (DM_stall !== 1'b1 || dm_req !== 1'b0) begin failures++;
      $display("FAIL rm_wait: got stall=%b req=%b exp 1/0", DM_stall, dm_req); end
    rst = 1'b1; mem_read = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; dm_rvalid = 1'b1; dm_rdata = 32'h11112222;
    #1;
    checks++; if (dm_req !== 1'b0 || ld_data !== 32'h0 || DM_stall !== 1'b0) begin failures++;
      $display("FAIL rm_reset: got req=%b ld=%h stall=%b exp 0/0/0", dm_req, ld_data, DM_stall); end
    @(posedge clk); #1;
    dm_rvalid = 1'b0;
    checks++; if (ld_data !== 32'h0 || dm_req !== 1'b0 || misalign !== 1'b0) begin failures++;
      $display("FAIL rm_ignore: got ld=%h req=%b mis=%b exp 0/0/0", ld_data, dm_req, misalign); end
  endtask

  initial begin
    rst = 1'b1; mem_read = 1'b0; mem_write = 1'b0; funct3 = 3'b000; addr = 32'h0;
    store_data = 32'h0; IM_stall = 1'b0; dm_gnt = 1'b0; dm_rvalid = 1'b0; dm_rdata = 32'h0;
    test_reset();
    test_load_word();
    test_load_byte_half();
    test_store();
    test_misaligned();
    test_backpressure();
    test_read_wins();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
